// File: rtl/sar_adc_pkg.sv
// Shared types, default sizes and the channel-index width helper for the
// multi-channel SAR ADC controller.
package sar_adc_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NCH_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_t;

    // A single-channel build still needs a 1-bit index port.
    function automatic int chw_f(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/sar_adc_mch_sar_step.sv
// One successive-approximation step: try the current bit on top of the
// partial result and keep it only if the held sample still covers the trial.
module sar_step #(
    parameter int WIDTH = 16,
    parameter int BW    = 4
) (
    input  logic [WIDTH-1:0] i_hold,
    input  logic [WIDTH-1:0] i_result,
    input  logic [BW-1:0]    i_bit,
    output logic [WIDTH-1:0] o_next
);

    logic [WIDTH-1:0] w_trial;

    assign w_trial = i_result | (WIDTH'(1) << i_bit);
    assign o_next  = (i_hold >= w_trial) ? w_trial : i_result;

endmodule

// File: rtl/sar_adc_mch.sv
// Multi-channel SAR ADC sequencer; define SAR_ADC_SCAN_EN to build the auto-scan
// option. States: IDLE wait | SAMPLE latch channel | CONVERT one bit/cycle | DONE result pulse
module sar_adc_mch
    import sar_adc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCH   = NCH_DEF,
    parameter int CHW   = chw_f(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHW-1:0]       ch_sel,
    input  logic                 scan_mode,
    input  logic [NCH*WIDTH-1:0] analog_in,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     digital_out,
    output logic [CHW-1:0]       ch_out,
    output logic                 err
);

    localparam int BW = $clog2(WIDTH);
    // One bit per encodable channel index; set only for channels that exist.
    localparam logic [(1<<CHW)-1:0] CH_MASK = {(1<<CHW){1'b1}} >> ((1<<CHW) - NCH);

    sar_state_t       r_state;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_result;
    logic [BW-1:0]    r_bit;
    logic [CHW-1:0]   r_ch;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_dout;
    logic [CHW-1:0]   r_chout;

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_next;
    logic             w_ch_ok;
    logic             w_auto;
    logic [CHW-1:0]   w_auto_ch;

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NCH; k++) begin
            if (r_ch == CHW'(k)) w_sel = analog_in[k*WIDTH +: WIDTH];
        end
    end

    assign w_ch_ok = CH_MASK[ch_sel];

`ifdef SAR_ADC_SCAN_EN
    assign w_auto    = (r_state == ST_DONE) && scan_mode;
    assign w_auto_ch = (r_chout == CHW'(NCH-1)) ? '0 : r_chout + CHW'(1);
`else
    logic w_unused_scan;
    assign w_unused_scan = scan_mode;
    assign w_auto        = 1'b0;
    assign w_auto_ch     = '0;
`endif

    sar_step #(.WIDTH(WIDTH), .BW(BW)) u_step (
        .i_hold   (r_hold),
        .i_result (r_result),
        .i_bit    (r_bit),
        .o_next   (w_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_hold   <= '0;
            r_result <= '0;
            r_bit    <= '0;
            r_ch     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_dout   <= '0;
            r_chout  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_auto) begin
                        r_state <= ST_SAMPLE;
                        r_ch    <= w_auto_ch;
                        r_busy  <= 1'b1;
                    end else if (start && w_ch_ok) begin
                        r_state <= ST_SAMPLE;
                        r_ch    <= ch_sel;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_err   <= start;
                    end
                end
                ST_SAMPLE: begin
                    r_hold   <= w_sel;
                    r_result <= '0;
                    r_bit    <= BW'(WIDTH-1);
                    r_state  <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    r_result <= w_next;
                    if (r_bit == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_dout  <= w_next;
                        r_chout <= r_ch;
                    end else begin
                        r_bit <= r_bit - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign digital_out = r_dout;
    assign ch_out      = r_chout;

endmodule

// File: tb/tb_sar_adc_mch.sv
// Bench for sar_adc_mch: transaction-level model checked every cycle, directed
// latency/boundary cases, a 3-channel build for rejected requests, then random traffic.
module tb_sar_adc_mch;

    localparam int W  = 16;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int W3 = 8;
    localparam int N3 = 3;
    localparam int C3 = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            scan_mode = 1'b0;
    logic [CW-1:0]   ch_sel = '0;
    logic [NC*W-1:0] ain = '0;
    logic            busy, done, err;
    logic [W-1:0]    dout;
    logic [CW-1:0]   chout;

    logic             s3_start = 1'b0;
    logic [C3-1:0]    s3_ch = '0;
    logic [N3*W3-1:0] a3 = '0;
    logic             b3, d3, e3;
    logic [W3-1:0]    o3;
    logic [C3-1:0]    c3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sar_adc_mch #(.WIDTH(W), .NCH(NC)) dut (
        .clk(clk), .reset(rst), .start(start), .ch_sel(ch_sel), .scan_mode(scan_mode),
        .analog_in(ain), .busy(busy), .done(done), .digital_out(dout), .ch_out(chout), .err(err)
    );

    sar_adc_mch #(.WIDTH(W3), .NCH(N3)) dut3 (
        .clk(clk), .reset(rst), .start(s3_start), .ch_sel(s3_ch), .scan_mode(1'b0),
        .analog_in(a3), .busy(b3), .done(d3), .digital_out(o3), .ch_out(c3), .err(e3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] chan(input logic [NC*W-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    // Reference: a request is honoured when nothing is in flight; the ideal
    // converter returns exactly the value held one edge after acceptance, and
    // the result appears W+1 edges after acceptance.
    logic         m_active = 1'b0;
    int           m_age = 0;
    int           m_ch = 0;
    logic [W-1:0] m_val = '0;
    logic         m_was_done = 1'b0;
    logic         e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    logic [W-1:0] e_dout = '0;
    int           e_ch = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_ch = 0; m_val = '0;
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_dout = '0; e_ch = 0;
        end else begin
            m_was_done = e_done;
            e_done = 1'b0;
            e_err  = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age == 1) m_val = chan(ain, m_ch);
                if (m_age == W + 1) begin
                    e_done = 1'b1; e_dout = m_val; e_ch = m_ch; m_active = 1'b0;
                end
            end else begin
`ifdef SAR_ADC_SCAN_EN
                if (m_was_done && scan_mode) begin
                    m_active = 1'b1; m_age = 0; m_ch = (e_ch + 1) % NC;
                end else
`endif
                if (start) begin
                    if (int'(ch_sel) < NC) begin
                        m_active = 1'b1; m_age = 0; m_ch = int'(ch_sel);
                    end else begin
                        e_err = 1'b1;
                    end
                end
            end
            e_busy = m_active;
        end
    end

    always @(negedge clk) begin
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("err", err, e_err);
        check("digital_out", dout, e_dout);
        check("ch_out", chout, e_ch);
    end

    // Called at a negedge with start already raised; drops start after acceptance.
    task automatic wait_done(input int lim, input int chg_i, input int chg_ch,
                             input logic [W-1:0] chg_v, output int busy_n, output int done_at);
        busy_n  = 0;
        done_at = 0;
        for (int i = 1; i <= lim && done_at == 0; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == chg_i) ain[chg_ch*W +: W] = chg_v;
            if (busy) busy_n++;
            if (done) done_at = i;
        end
    endtask

    initial begin
        int bn, da, d1, d2, errseen, d3at;
        logic [W-1:0] v1, v2;
        logic [W3-1:0] r3;

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Rejected and ignored requests on a 3-channel build.
        @(negedge clk);
        a3 = {8'h33, 8'hC7, 8'h11};
        s3_start = 1'b1; s3_ch = 2'd3;
        @(negedge clk);
        check("r033_err_pulse", e3, 1'b1);
        check("r033_err_no_busy", b3, 1'b0);
        s3_start = 1'b0;
        @(negedge clk);
        check("r033_err_one_cycle", e3, 1'b0);
        s3_start = 1'b1; s3_ch = 2'd1;
        @(negedge clk);
        check("r033_valid_busy", b3, 1'b1);
        errseen = 0; d3at = 0; r3 = '0;
        for (int i = 2; i <= 30 && d3at == 0; i++) begin
            @(negedge clk);
            if (i == 2) s3_ch = 2'd3;
            if (i == 5) s3_start = 1'b0;
            if (e3) errseen = 1;
            if (d3) begin d3at = i; r3 = o3; end
        end
        check("r033_busy_no_err", errseen, 0);
        check("r033_done_at", d3at, W3 + 2);
        check("r033_result", r3, 8'hC7);
        check("r033_chout", c3, 2'd1);

        // Single conversion latency and result.
        @(negedge clk);
        ain[2*W +: W] = 16'hA5A5; start = 1'b1; ch_sel = 2'd2;
        wait_done(40, 0, 0, '0, bn, da);
        check("r029_busy_cycles", bn, 17);
        check("r029_done_at", da, 18);
        check("r029_dout", dout, 16'hA5A5);
        check("r029_chout", chout, 2'd2);

        // Back-to-back with start held: zero then full scale.
        @(negedge clk);
        ain[0 +: W] = 16'h0000; ain[W +: W] = 16'hFFFF; start = 1'b1; ch_sel = 2'd0;
        d1 = 0; d2 = 0; v1 = '1; v2 = '0;
        for (int i = 1; i <= 60 && d2 == 0; i++) begin
            @(negedge clk);
            if (i == 1) ch_sel = 2'd1;
            if (i == 19) start = 1'b0;
            if (done) begin
                if (d1 == 0) begin d1 = i; v1 = dout; end
                else begin d2 = i; v2 = dout; end
            end
        end
        check("r030_first_done", d1, 18);
        check("r030_spacing", d2 - d1, 18);
        check("r030_zero", v1, 16'h0000);
        check("r030_full", v2, 16'hFFFF);

        // Input change after the sample edge must not leak in.
        @(negedge clk);
        ain[3*W +: W] = 16'h1234; start = 1'b1; ch_sel = 2'd3;
        wait_done(40, 2, 3, 16'hFFFF, bn, da);
        check("r031_done_at", da, 18);
        check("r031_dout", dout, 16'h1234);
        check("r031_chout", chout, 2'd3);

        // Reset in the middle of a conversion.
        @(negedge clk);
        ain[W +: W] = 16'h5A3C; start = 1'b1; ch_sel = 2'd1;
        errseen = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) errseen = 1;
        end
        check("r032_busy_before", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("r032_busy_abort", busy, 1'b0);
        check("r032_dout_clear", dout, 16'h0000);
        check("r032_chout_clear", chout, 2'd0);
        @(negedge clk);
        if (done) errseen = 1;
        @(negedge clk);
        if (done) errseen = 1;
        check("r032_no_done", errseen, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        start = 1'b1; ch_sel = 2'd1;
        wait_done(40, 0, 0, '0, bn, da);
        check("r032_fresh_done_at", da, 18);
        check("r032_fresh_dout", dout, 16'h5A3C);

`ifdef SAR_ADC_SCAN_EN
        @(negedge clk);
        ain = {16'hDEAD, 16'h0F0F, 16'h8001, 16'h7FFE};
        scan_mode = 1'b1; start = 1'b1; ch_sel = 2'd0;
        d1 = 0;
        for (int i = 1; i <= 200 && d1 < 5; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin
                check("r034_chout", chout, d1 % NC);
                check("r034_dout", dout, chan(ain, d1 % NC));
                d1++;
                if (d1 == 5) scan_mode = 1'b0;
            end
        end
        check("r034_count", d1, 5);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            ch_sel    = CW'($urandom_range(0, NC - 1));
            scan_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0:       v1 = '0;
                    1:       v1 = '1;
                    default: v1 = W'($urandom);
                endcase
                ain[$urandom_range(0, NC - 1)*W +: W] = v1;
            end
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end

        start = 1'b0;
        scan_mode = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
